// File: rtl/instruction_cache.sv
// Direct-mapped read-only L1 I-cache: zero-latency hits, one 256-bit line fill per miss.
// Miss costs memory latency + 2 cycles; fetch stalls while inst_resp is low.
module instruction_cache #(
  parameter int  S_INDEX  = 3,
  parameter int  S_OFFSET = 5,
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX,
  localparam int SETS     = 1 << S_INDEX,
  localparam int LINE_W   = 8 << S_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [31:0]       inst_addr,
  output logic              inst_resp,
  output logic [31:0]       inst_rdata,
  input  logic              flush,
  output logic              pmem_read,
  output logic [31:0]       pmem_address,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  typedef enum logic {IDLE, MISS} state_t;

  state_t state;
  state_t state_next;

  logic [S_TAG-1:0]    req_tag;
  logic [S_INDEX-1:0]  req_index;
  logic [S_OFFSET-3:0] req_word;
  logic                unused_addr_bits;

  assign req_tag          = inst_addr[31 -: S_TAG];
  assign req_index        = inst_addr[S_OFFSET +: S_INDEX];
  assign req_word         = inst_addr[S_OFFSET-1:2];
  assign unused_addr_bits = ^inst_addr[1:0];

  logic [SETS-1:0]   valid;
  logic [S_TAG-1:0]  tag_arr  [SETS];
  logic [LINE_W-1:0] data_arr [SETS];

  logic [LINE_W-1:0]  sel_line;
  logic               hit;
  logic               start_miss;
  logic               fill;
  logic               discard;
  logic [S_TAG-1:0]   fill_tag;
  logic [S_INDEX-1:0] fill_index;

  // The latched line address doubles as the fill target, so a redirect mid-miss cannot retarget it.
  assign fill_tag   = pmem_address[31 -: S_TAG];
  assign fill_index = pmem_address[S_OFFSET +: S_INDEX];

  assign sel_line   = data_arr[req_index];
  assign hit        = inst_read && valid[req_index] && (tag_arr[req_index] == req_tag);
  assign start_miss = (state == IDLE) && inst_read && !hit && !flush;
  assign fill       = (state == MISS) && pmem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_miss) state_next = MISS;
      MISS: if (pmem_resp)  state_next = IDLE;
    endcase
  end

  always_comb begin
    inst_resp  = 1'b0;
    inst_rdata = '0;
    if ((state == IDLE) && hit && !flush) begin
      inst_resp  = 1'b1;
      inst_rdata = sel_line[{req_word, 5'd0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid        <= '0;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
      discard      <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      // Flush wins over a coincident fill so the returning line is never marked valid.
      if (flush) begin
        valid <= '0;
      end else if (fill && !discard) begin
        valid[fill_index] <= 1'b1;
      end

      if (fill) begin
        discard <= 1'b0;
      end else if ((state == MISS) && flush) begin
        discard <= 1'b1;
      end

      if (start_miss) begin
        pmem_read    <= 1'b1;
        pmem_address <= {req_tag, req_index, {S_OFFSET{1'b0}}};
      end else if (fill) begin
        pmem_read    <= 1'b0;
      end

      if (inst_resp && (hit_count != '1)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_miss && (miss_count != '1)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_arr[fill_index] <= pmem_rdata;
      tag_arr[fill_index]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a scoreboard of expected fetch words.
module tb_instruction_cache;
  localparam int MEM_LAT = 3;
  localparam int MISS_LAT = MEM_LAT + 2;
  localparam int REMISS_LAT = 2 * MEM_LAT + 4;

  logic         clk;
  logic         rst;
  logic         inst_read;
  logic [31:0]  inst_addr;
  logic         inst_resp;
  logic [31:0]  inst_rdata;
  logic         flush;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  instruction_cache dut (
    .clk(clk), .rst(rst), .inst_read(inst_read), .inst_addr(inst_addr),
    .inst_resp(inst_resp), .inst_rdata(inst_rdata), .flush(flush),
    .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} << 4) ^ 32'h0000_0613;
  endfunction

  function automatic logic [255:0] make_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({a[31:5], 5'b0} + 32'(4 * w));
    return l;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one fetch, plays memory, and compares the word when inst_resp shows up.
  task automatic fetch(input logic [31:0] addr, input int exp_lat, input int flush_at,
                       input int redir_at, input logic [31:0] redir_addr);
    logic [31:0]  prev;
    logic [31:0]  exp_w;
    logic [255:0] resp_line;
    int  rd;
    int  cyc;
    bit  resp_next;
    bit  done;
    @(posedge clk); #1;
    inst_read = 1'b1;
    inst_addr = addr;
    flush     = 1'b0;
    pmem_resp = 1'b0;
    sb.push_back(mem_word((redir_at >= 0) ? redir_addr : addr));
    prev = addr; rd = 0; cyc = 0; done = 1'b0; resp_next = 1'b0; resp_line = '0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (inst_resp) begin
        exp_w = sb.pop_front();
        check("rdata", inst_rdata, exp_w);
        check("latency", cyc, exp_lat);
        check("pmem_read_on_hit", {31'b0, pmem_read}, 32'd0);
        done = 1'b1;
      end else begin
        check("rdata_zero_on_stall", inst_rdata, 32'd0);
        rd = pmem_read ? rd + 1 : 0;
        if (rd == 1) check("pmem_address", pmem_address, {prev[31:5], 5'b0});
        resp_next = (rd == MEM_LAT);
        if (resp_next) resp_line = make_line(pmem_address);
        prev = inst_addr;
        @(posedge clk); #1;
        cyc++;
        pmem_resp = resp_next;
        if (resp_next) pmem_rdata = resp_line;
        flush = (cyc == flush_at);
        if (cyc == redir_at) inst_addr = redir_addr;
      end
    end
    check("fetch_done", {31'b0, done}, 32'd1);
    if (!done && sb.size() > 0) void'(sb.pop_front());
    pmem_resp = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; inst_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; inst_read = 1'b0; inst_addr = 32'h60; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    #2;
    check("rst_inst_resp",  {31'b0, inst_resp}, 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_pmem_read",  {31'b0, pmem_read}, 32'd0);
    check("rst_pmem_addr",  pmem_address, 32'd0);
    check("rst_hit_count",  hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Cold miss then same-line hits
    fetch(32'h60, MISS_LAT, -1, -1, 32'h0);
    check("rdata_0x60", inst_rdata, 32'h0000_0013);
    check("miss_count_1", miss_count, 32'd1);
    fetch(32'h64, 0, -1, -1, 32'h0);
    fetch(32'h68, 0, -1, -1, 32'h0);
    fetch(32'h7C, 0, -1, -1, 32'h0);
    @(posedge clk); #1;
    inst_read = 1'b0;
    @(negedge clk);
    check("hit_count_4", hit_count, 32'd4);
    check("miss_count_still_1", miss_count, 32'd1);

    // Conflict misses in set 0
    do_reset();
    fetch(32'h000, MISS_LAT, -1, -1, 32'h0);
    fetch(32'h100, MISS_LAT, -1, -1, 32'h0);
    fetch(32'h000, MISS_LAT, -1, -1, 32'h0);
    check("miss_count_3", miss_count, 32'd3);

    // Flush during MISS and flush coincident with the fill
    fetch(32'h120, MISS_LAT, -1, -1, 32'h0);
    fetch(32'h100, MISS_LAT, -1, -1, 32'h0);
    fetch(32'h200, REMISS_LAT, 2, -1, 32'h0);
    fetch(32'h120, MISS_LAT, -1, -1, 32'h0);
    fetch(32'h100, REMISS_LAT, MISS_LAT - 1, -1, 32'h0);
    check("miss_count_flush", miss_count, 32'd10);

    // Redirect mid-MISS: old fill still lands
    fetch(32'h300, REMISS_LAT, -1, 2, 32'h440);
    fetch(32'h300, 0, -1, -1, 32'h0);

    // Flush in IDLE suppresses the hit and issues no miss
    @(posedge clk); #1;
    inst_addr = 32'h300; inst_read = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_resp",  {31'b0, inst_resp}, 32'd0);
    check("flush_idle_rdata", inst_rdata, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; inst_read = 1'b0;
    @(negedge clk);
    check("flush_idle_no_miss", {31'b0, pmem_read}, 32'd0);
    fetch(32'h300, MISS_LAT, -1, -1, 32'h0);

    // Reset while a miss is outstanding, then a stale pmem_resp
    @(posedge clk); #1;
    inst_addr = 32'h500; inst_read = 1'b1;
    @(posedge clk); #1;
    check("mid_miss_pmem_read", {31'b0, pmem_read}, 32'd1);
    rst = 1'b0; inst_read = 1'b0;
    #1;
    check("async_rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check("async_rst_hit_count", hit_count, 32'd0);
    check("async_rst_miss_count", miss_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = make_line(32'h500);
    @(negedge clk);
    check("stale_resp_pmem_read", {31'b0, pmem_read}, 32'd0);
    check("stale_resp_inst_resp", {31'b0, inst_resp}, 32'd0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    fetch(32'h500, MISS_LAT, -1, -1, 32'h0);
    check("miss_count_after_rst", miss_count, 32'd1);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
